// File: rtl/systolic_feeder.sv
// Skewed operand feeder for a 4x4 systolic array: latches X and Y on start,
// clears the PE accumulators, streams 7 diagonal beats, drains, then pulses done.
module systolic_feeder #(
  parameter int DW           = 16,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [16*DW-1:0]  mat_x,
  input  logic [16*DW-1:0]  mat_y,
  output logic [4*DW-1:0]   a,
  output logic [4*DW-1:0]   b,
  output logic              acc_clr,
  output logic              busy,
  output logic              done
);

  localparam int CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         t, t_nxt;
  logic [CW-1:0]      dcnt, dcnt_nxt;
  logic [16*DW-1:0]   x_q, y_q;

  logic [4*DW-1:0]    a_nxt, b_nxt;
  logic               acc_clr_nxt, busy_nxt, done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      dcnt  <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      dcnt  <= dcnt_nxt;
      if (state == IDLE && start) begin
        x_q <= mat_x;
        y_q <= mat_y;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    dcnt_nxt  = dcnt;
    case (state)
      IDLE:  if (start) state_nxt = CLEAR;
      CLEAR: begin
        state_nxt = FEED;
        t_nxt     = '0;
      end
      FEED: begin
        if (t == 3'd6) begin
          state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
          dcnt_nxt  = CW'(DRAIN_CYCLES - 1);
        end else begin
          t_nxt = t + 3'd1;
        end
      end
      DRAIN: begin
        if (dcnt == '0) state_nxt = DONE;
        else            dcnt_nxt  = dcnt - 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up
  // with the state they describe; beat t pairs lane l with row/col s where s+l==t.
  always_comb begin
    a_nxt       = '0;
    b_nxt       = '0;
    acc_clr_nxt = (state_nxt == CLEAR);
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == DONE);
    if (state_nxt == FEED) begin
      for (int unsigned l = 0; l < 4; l++) begin
        for (int unsigned s = 0; s < 4; s++) begin
          if (32'(t_nxt) == s + l) begin
            a_nxt[DW*l +: DW] = y_q[DW*(4*s+l) +: DW];
            b_nxt[DW*l +: DW] = x_q[DW*(4*l+s) +: DW];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      acc_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      a       <= a_nxt;
      b       <= b_nxt;
      acc_clr <= acc_clr_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: beat pattern, timing, ignored starts,
// mid-run reset, input stability and an end-to-end systolic array model.
module tb_systolic_feeder;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [16*DW-1:0]  mat_x, mat_y;
  logic [4*DW-1:0]   a, b;
  logic              acc_clr, busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt;
  logic [4*DW-1:0] cap_a [7];
  logic [4*DW-1:0] cap_b [7];

  always #5 clk = ~clk;

  systolic_feeder #(.DW(DW), .DRAIN_CYCLES(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mat_x   (mat_x),
    .mat_y   (mat_y),
    .a       (a),
    .b       (b),
    .acc_clr (acc_clr),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] el(input logic [16*DW-1:0] m, input int r, input int c);
    return m[DW*(4*r+c) +: DW];
  endfunction

  // kind: 0 X pattern, 1 Y pattern, 2 identity, 3 all ones, 4 arbitrary with MSB set
  function automatic logic [16*DW-1:0] mat_fn(input int kind);
    logic [16*DW-1:0] m;
    m = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        case (kind)
          0: m[DW*(4*r+c) +: DW] = 16'(4*r + c + 1);
          1: m[DW*(4*r+c) +: DW] = 16'(16 + 4*r + c);
          2: m[DW*(4*r+c) +: DW] = (r == c) ? 16'd1 : 16'd0;
          3: m[DW*(4*r+c) +: DW] = 16'd1;
          default: m[DW*(4*r+c) +: DW] = 16'(32'h8001 + r*32'h1111 + c*32'h0203);
        endcase
    return m;
  endfunction

  function automatic logic [4*DW-1:0] exp_beat(input logic [16*DW-1:0] m, input int t, input bit is_a);
    logic [4*DW-1:0] v;
    v = '0;
    for (int lane = 0; lane < 4; lane++) begin
      int s;
      s = t - lane;
      if (s >= 0 && s <= 3)
        v[DW*lane +: DW] = is_a ? el(m, s, lane) : el(m, lane, s);
    end
    return v;
  endfunction

  function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  // PE(k,l) meets a-lane l delayed k beats and b-lane k delayed l beats.
  function automatic logic [31:0] cres(input int k, input int l);
    logic [31:0] acc;
    acc = '0;
    for (int p = 0; p < 7; p++) begin
      int q;
      q = p + k - l;
      if (q >= 0 && q <= 6)
        acc += 32'(cap_a[p][DW*l +: DW]) * 32'(cap_b[q][DW*k +: DW]);
    end
    return acc;
  endfunction

  task automatic run(input logic [16*DW-1:0] xm, input logic [16*DW-1:0] ym,
                     input bit scramble, input bit poke);
    mat_x = xm;
    mat_y = ym;
    start = 1'b1;
    step();
    start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      chk($sformatf("busy@c%0d", c), 64'(busy), 64'(c >= 1 && c <= 17));
      chk($sformatf("done@c%0d", c), 64'(done), 64'(c == 17));
      chk($sformatf("acc_clr@c%0d", c), 64'(acc_clr), 64'(c == 1));
      if (c >= 2 && c <= 8) begin
        cap_a[c-2] = a;
        cap_b[c-2] = b;
        chk($sformatf("a_beat%0d", c-2), a, exp_beat(ym, c-2, 1'b1));
        chk($sformatf("b_beat%0d", c-2), b, exp_beat(xm, c-2, 1'b0));
      end else begin
        chk($sformatf("a_zero@c%0d", c), a, 64'd0);
        chk($sformatf("b_zero@c%0d", c), b, 64'd0);
      end
      if (done) done_cnt++;
      if (scramble) begin
        for (int i = 0; i < 8; i++) begin
          mat_x[32*i +: 32] = $urandom;
          mat_y[32*i +: 32] = $urandom;
        end
      end
      start = poke && (c == 4 || c == 17);
      step();
    end
    start = 1'b0;
    chk("done_count", 64'(done_cnt), 64'd1);
  endtask

  logic [63:0] ha [7];
  logic [63:0] hb [7];

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mat_x = '0;
    mat_y = '0;
    step();
    step();
    chk("rst_a", a, 64'd0);
    chk("rst_b", b, 64'd0);
    chk("rst_acc_clr", 64'(acc_clr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    step();

    // Beat pattern with inputs scrambled every cycle after acceptance
    run(mat_fn(0), mat_fn(1), 1'b1, 1'b0);
    ha[0] = pk(16, 0, 0, 0);   hb[0] = pk(1, 0, 0, 0);
    ha[1] = pk(20, 17, 0, 0);  hb[1] = pk(2, 5, 0, 0);
    ha[2] = pk(24, 21, 18, 0); hb[2] = pk(3, 6, 9, 0);
    ha[3] = pk(28, 25, 22, 19); hb[3] = pk(4, 7, 10, 13);
    ha[4] = pk(0, 29, 26, 23); hb[4] = pk(0, 8, 11, 14);
    ha[5] = pk(0, 0, 30, 27);  hb[5] = pk(0, 0, 12, 15);
    ha[6] = pk(0, 0, 0, 31);   hb[6] = pk(0, 0, 0, 16);
    for (int t = 0; t < 7; t++) begin
      chk($sformatf("hand_a%0d", t), cap_a[t], ha[t]);
      chk($sformatf("hand_b%0d", t), cap_b[t], hb[t]);
    end

    // Identity X with starts poked during FEED and DONE
    run(mat_fn(2), mat_fn(4), 1'b0, 1'b1);
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < 4; l++)
        chk($sformatf("ident_C%0d%0d", k, l), 64'(cres(k, l)), 64'(el(mat_fn(4), k, l)));

    run(mat_fn(3), mat_fn(3), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < 4; l++)
        chk($sformatf("ones_C%0d%0d", k, l), 64'(cres(k, l)), 64'd4);

    // Reset during FEED beat 4
    mat_x = mat_fn(0);
    mat_y = mat_fn(1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_a", a, pk(0, 29, 26, 23));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_a", a, 64'd0);
    chk("mid_rst_b", b, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_acc_clr", 64'(acc_clr), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", 64'(busy), 64'd0);
    run(mat_fn(3), mat_fn(4), 1'b0, 1'b0);

    // start held high: one idle cycle between back-to-back runs
    mat_x = mat_fn(0);
    mat_y = mat_fn(1);
    start = 1'b1;
    step();
    for (int c = 1; c <= 20; c++) begin
      chk($sformatf("b2b_busy@c%0d", c), 64'(busy), 64'(c != 18));
      chk($sformatf("b2b_acc_clr@c%0d", c), 64'(acc_clr), 64'(c == 1 || c == 19));
      chk($sformatf("b2b_done@c%0d", c), 64'(done), 64'(c == 17));
      step();
    end
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("b2b_idle_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
